// File: rtl/io_arb_pkg.sv
// Shared state encoding and width defaults for the two-requester IO bus arbiter.
package io_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int AW_DEFAULT = 12;
    localparam int DW_DEFAULT = 32;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the most recent winner.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] winner
);
    // 1 = requester 1 won most recently, so requester 0 takes the next tie
    logic last;

    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            last <= winner[1];
        end
    end
endmodule

// File: rtl/io_arbiter.sv
// Arbitrates CPU (0) and DMA (1) transfers onto a single IO module bus,
// one transfer at a time through IDLE -> ACCESS -> DONE.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          io_cs,
    output logic          io_rd,
    output logic          io_wr,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] IO_in,
    input  logic [DW-1:0] IO_out,
    output state_t        dbg_state
);
    // Handshake: a requester raises req with wr/addr/wdata and may drop or change
    // them once its gnt is seen; gnt marks the bus cycle, ack (with err) closes it.
    localparam logic [AW-1:0] ADDR_LAST = {{(AW-2){1'b1}}, 2'b00};

    state_t        state, state_next;
    logic [1:0]    req_vec, winner;
    logic          start;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          win1_q, wr_q, bad_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    assign req_vec   = {req1, req0};
    assign start     = (state == IDLE) && (req_vec != 2'b00);
    assign sel_wr    = winner[1] ? wr1 : wr0;
    assign sel_addr  = winner[1] ? addr1 : addr0;
    assign sel_wdata = winner[1] ? wdata1 : wdata0;
    assign dbg_state = state;

    rr_arb2 u_rr_arb2 (
        .clock  (clock),
        .reset  (reset),
        .req    (req_vec),
        .update (start),
        .winner (winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_vec != 2'b00) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The winner's request is frozen here so requesters are free after the grant edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            win1_q  <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            win1_q  <= winner[1];
            wr_q    <= sel_wr;
            bad_q   <= sel_addr > ADDR_LAST;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if ((state == ACCESS) && !wr_q && !bad_q) begin
            rdata <= IO_out;
        end
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        err0    = 1'b0;
        err1    = 1'b0;
        io_cs   = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        Address = '0;
        IO_in   = '0;
        case (state)
            ACCESS: begin
                gnt0 = !win1_q;
                gnt1 = win1_q;
                // An out-of-range word never reaches the IO module
                if (!bad_q) begin
                    io_cs   = 1'b1;
                    io_rd   = !wr_q;
                    io_wr   = wr_q;
                    Address = addr_q;
                    IO_in   = wdata_q;
                end
            end
            DONE: begin
                ack0 = !win1_q;
                ack1 = win1_q;
                err0 = !win1_q && bad_q;
                err1 = win1_q && bad_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a cycle-scheduled transaction model.
module tb_io_arbiter;
    import io_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [AW-1:0] LAST_OK = 12'hFFC;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic          io_cs, io_rd, io_wr;
    logic [AW-1:0] Address;
    logic [DW-1:0] IO_in, IO_out;
    state_t        dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    io_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .ack0     (ack0),
        .ack1     (ack1),
        .err0     (err0),
        .err1     (err1),
        .rdata    (rdata),
        .io_cs    (io_cs),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .Address  (Address),
        .IO_in    (IO_in),
        .IO_out   (IO_out),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] pattern(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // ---------------- IO module: word-addressed memory ----------------
    logic          mem_init;
    logic [DW-1:0] dev_mem [1024];

    assign IO_out = dev_mem[Address[11:2]];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= pattern(i);
        end else if (io_cs && io_wr) begin
            dev_mem[Address[11:2]] <= IO_in;
        end
    end

    // ---------------- transaction-schedule reference model ----------------
    logic [DW-1:0] model_mem [1024];
    int            cyc = 0;
    bit            armed = 1'b0;
    int            next_sample = 0;
    int            acc_cyc = -1;
    int            ack_cyc = -1;
    bit            last_one = 1'b1;
    bit            t_win, t_wr, t_bad;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] exp_rdata;
    bit            in_acc, in_ack, e_cs;

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = pattern(i);
    end

    always @(negedge clock) begin
        in_acc = (cyc == acc_cyc);
        in_ack = (cyc == ack_cyc);
        e_cs   = in_acc && !t_bad;
        if (armed) begin
            chk("gnt0", 64'(gnt0), 64'(in_acc && !t_win));
            chk("gnt1", 64'(gnt1), 64'(in_acc && t_win));
            chk("ack0", 64'(ack0), 64'(in_ack && !t_win));
            chk("ack1", 64'(ack1), 64'(in_ack && t_win));
            chk("err0", 64'(err0), 64'(in_ack && !t_win && t_bad));
            chk("err1", 64'(err1), 64'(in_ack && t_win && t_bad));
            chk("io_cs", 64'(io_cs), 64'(e_cs));
            chk("io_rd", 64'(io_rd), 64'(e_cs && !t_wr));
            chk("io_wr", 64'(io_wr), 64'(e_cs && t_wr));
            if (!(in_acc && t_bad)) begin
                chk("Address", 64'(Address), e_cs ? 64'(t_addr) : 64'd0);
                chk("IO_in", 64'(IO_in), e_cs ? 64'(t_wdata) : 64'd0);
            end
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            if (e_cs && t_wr) model_mem[t_addr[11:2]] = t_wdata;
        end
        if (reset) begin
            armed       = 1'b1;
            acc_cyc     = -1;
            ack_cyc     = -1;
            next_sample = cyc + 1;
            last_one    = 1'b1;
            exp_rdata   = '0;
        end else if (armed) begin
            if (e_cs && !t_wr) exp_rdata = model_mem[t_addr[11:2]];
            if ((cyc >= next_sample) && (req0 || req1)) begin
                t_win       = (req0 && req1) ? !last_one : req1;
                last_one    = t_win;
                t_wr        = t_win ? wr1 : wr0;
                t_addr      = t_win ? addr1 : addr0;
                t_wdata     = t_win ? wdata1 : wdata0;
                t_bad       = t_addr > LAST_OK;
                acc_cyc     = cyc + 1;
                ack_cyc     = cyc + 2;
                next_sample = cyc + 3;
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return 12'hFF0 + 12'($urandom_range(0, 15));
        return 12'($urandom_range(0, 63));
    endfunction

    initial begin
        mem_init = 1'b1;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clock);
        #1;
        mem_init = 1'b0;
        reset = 1'b0;
        chk("reset_io_cs", 64'(io_cs), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);

        // CPU write 0x010 <- DEADBEEF
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h010; wdata0 = 32'hDEADBEEF;
        step();
        req0 = 1'b0; wr0 = 1'b0;
        chk("wr_io_cs", 64'(io_cs), 64'd1);
        chk("wr_io_wr", 64'(io_wr), 64'd1);
        chk("wr_addr", 64'(Address), 64'h010);
        chk("wr_gnt0", 64'(gnt0), 64'd1);
        step();
        chk("wr_ack0", 64'(ack0), 64'd1);
        chk("wr_err0", 64'(err0), 64'd0);

        // DMA read-back, request raised during DONE
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h010;
        step();
        step();
        req1 = 1'b0;
        chk("rd_io_rd", 64'(io_rd), 64'd1);
        chk("rd_gnt1", 64'(gnt1), 64'd1);
        step();
        chk("rd_ack1", 64'(ack1), 64'd1);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);

        // Both requesters held from reset: strict alternation
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; addr0 = 12'h010; addr1 = 12'h010;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt0", 64'(gnt0), 64'(k % 2 == 0));
            chk("rr_gnt1", 64'(gnt1), 64'(k % 2 == 1));
            step();
            chk("rr_ack0", 64'(ack0), 64'(k % 2 == 0));
            chk("rr_ack1", 64'(ack1), 64'(k % 2 == 1));
            step();
        end

        // Out-of-range read
        req1 = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'hFFE;
        step();
        req0 = 1'b0;
        chk("oor_io_cs", 64'(io_cs), 64'd0);
        chk("oor_gnt0", 64'(gnt0), 64'd1);
        step();
        chk("oor_ack0", 64'(ack0), 64'd1);
        chk("oor_err0", 64'(err0), 64'd1);
        chk("oor_rdata", 64'(rdata), 64'hDEADBEEF);

        // Reset during ACCESS aborts, then a fresh read completes
        step();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h020;
        step();
        req0 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_io_cs", 64'(io_cs), 64'd0);
        chk("abort_gnt0", 64'(gnt0), 64'd0);
        chk("abort_rdata", 64'(rdata), 64'd0);
        step();
        chk("abort_no_ack", 64'(ack0), 64'd0);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h010;
        step();
        req0 = 1'b0;
        chk("fresh_gnt0", 64'(gnt0), 64'd1);
        step();
        chk("fresh_ack0", 64'(ack0), 64'd1);
        chk("fresh_rdata", 64'(rdata), 64'hDEADBEEF);

        // Random traffic, inputs change every cycle, occasional reset
        repeat (600) begin
            step();
            reset  = ($urandom_range(0, 63) == 0);
            req0   = ($urandom_range(0, 2) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            wr0    = 1'($urandom_range(0, 1));
            wr1    = 1'($urandom_range(0, 1));
            addr0  = rand_addr();
            addr1  = rand_addr();
            wdata0 = $urandom;
            wdata1 = $urandom;
        end
        step();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter: AW, default 12, IO address width.
REQ-002 Parameter: DW, default 32, IO data width.
REQ-003 Port: clock  in  1  sole clock; all state updates on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: req0, req1  in  1  transfer request from requester 0 (CPU) and requester 1 (DMA).
REQ-006 Ports: wr0, wr1  in  1  1 = write, 0 = read; qualified by the matching req.
REQ-007 Ports: addr0, addr1  in  AW  byte address of a 4-byte big-endian word.
REQ-008 Ports: wdata0, wdata1  in  DW  write data.
REQ-009 Ports: gnt0, gnt1  out  1  requester owns the IO bus this cycle.
REQ-010 Ports: ack0, ack1  out  1  one-cycle transfer-complete pulse.
REQ-011 Ports: err0, err1  out  1  valid with ack; transfer rejected.
REQ-012 Port: rdata  out  DW  registered read data; valid in the ack cycle, held until the next read completes.
REQ-013 Ports: io_cs, io_rd, io_wr  out  1  IO module enables.
REQ-014 Port: Address  out  AW  IO module address.
REQ-015 Ports: IO_in  out  DW, IO_out  in  DW  write and read data toward and from the IO module.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; IDLE -> ACCESS on any req; ACCESS -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-017 Requests are sampled only in IDLE; a req held through DONE counts as a new request on the next IDLE cycle.
REQ-018 Arbitration is round-robin over a 1-bit last-winner pointer (reset 1, so req0 wins the first tie); a lone requester always wins; the pointer updates on the IDLE->ACCESS edge.
REQ-019 Winner's wr/addr/wdata are latched on the IDLE->ACCESS edge; requester changes after that edge have no effect on the transfer.
REQ-020 In ACCESS: gnt of the winner = 1, io_cs = 1, io_rd = ~wr, io_wr = wr, Address = latched addr, IO_in = latched wdata.
REQ-021 Read: IO_out is captured into rdata on the ACCESS->DONE edge.
REQ-022 In DONE: ack of the winner = 1 for exactly one cycle; io_cs/io_rd/io_wr = 0.
REQ-023 Latency: req high in IDLE cycle N -> access in cycle N+1 -> ack in cycle N+2; back-to-back transfers issue at most one every 3 cycles.
REQ-024 Range check: latched addr > 2^AW-4 (e.g. 12'hFFD..12'hFFF) gives no access; io_cs stays 0 in ACCESS, ack and err assert in DONE, and rdata is unchanged.
REQ-025 Outside ACCESS: io_cs/io_rd/io_wr = 0, Address = 0, IO_in = 0, and both gnt = 0.
REQ-026 At most one gnt and at most one ack are high in any cycle; gnt and ack never coincide.

Reset
REQ-027 Reset forces IDLE; pointer = 1; gnt, ack, err, io_cs, io_rd, io_wr = 0; Address, IO_in, rdata = 0.
REQ-028 Reset asserted in ACCESS or DONE aborts the transfer: no ack is issued, and io_cs = 0 from the next cycle.
REQ-029 Reset has priority over every other event in the same cycle.

Structure
REQ-030 Shared package io_arb_pkg holds the state enum (IDLE, ACCESS, DONE) and the AW/DW defaults.
REQ-031 One sub-module, rr_arb2, holds the 2-input round-robin arbiter and the pointer (inputs req[1:0], update; output one-hot winner).

Verification
REQ-032 Reset, then req0 write addr 12'h010 data 32'hDEADBEEF -> cycle+1 io_cs=1, io_wr=1, Address=12'h010; cycle+2 ack0=1, err0=0.
REQ-033 req1 read addr 12'h010 after REQ-032 -> io_rd=1 in ACCESS; ack1 with rdata=32'hDEADBEEF.
REQ-034 req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1 with one ack every 3 cycles.
REQ-035 req0 read addr 12'hFFE -> io_cs stays 0; ack0=1 and err0=1; rdata unchanged.
REQ-036 Reset pulsed in the ACCESS cycle -> no ack; all outputs at reset values the next cycle; a fresh req then completes normally.
